// File: rtl/stall_controller.sv
// Pipeline stall/flush controller for a five-stage LC-3b core.
// Generates stage-register enables and bubbles; counts cycles in which the PC is held.
module stall_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_resp,
    input  logic        dmem_resp,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic        de_ex_valid,
    input  logic        ex_mem_valid,
    input  logic        br_taken,
    input  logic [3:0]  de_ex_opcode,   // lc3b_opcode
    input  logic [2:0]  de_ex_dr,       // lc3b_reg
    input  logic [2:0]  if_de_rs,       // lc3b_reg
    input  logic [2:0]  if_de_rt,       // lc3b_reg
    input  logic        if_de_uses_rs,
    input  logic        if_de_uses_rt,
    output logic        pc_load,
    output logic        if_de_load,
    output logic        de_ex_load,
    output logic        ex_mem_load,
    output logic        mem_wb_load,
    output logic        if_de_bubble,
    output logic        de_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        mem_wb_bubble,
    output logic        pc_sel_target,
    output logic        drain,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;

    state_t      state_q, state_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic is_load;
    logic dmem_wait;
    logic load_use;
    logic flush;

    always_comb begin
        is_load   = (de_ex_opcode == OP_LDR) || (de_ex_opcode == OP_LDB) ||
                    (de_ex_opcode == OP_LDI);
        dmem_wait = ex_mem_valid & (dmem_read | dmem_write) & ~dmem_resp;
        load_use  = de_ex_valid & is_load &
                    ((if_de_uses_rs & (de_ex_dr == if_de_rs)) |
                     (if_de_uses_rt & (de_ex_dr == if_de_rt)));
        flush     = ex_mem_valid & br_taken & ~dmem_wait;
    end

    // NOTE: every output and state_d gets a default before the priority chain,
    // so no path through this block can leave a variable unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        pc_load       = 1'b1;
        if_de_load    = 1'b1;
        de_ex_load    = 1'b1;
        ex_mem_load   = 1'b1;
        mem_wb_load   = 1'b1;
        if_de_bubble  = 1'b0;
        de_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        pc_sel_target = 1'b0;

        if (reset) begin
            pc_load       = 1'b0;
            if_de_bubble  = 1'b1;
            de_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = RUN;
        end else if (dmem_wait) begin
            pc_load       = 1'b0;
            if_de_load    = 1'b0;
            de_ex_load    = 1'b0;
            ex_mem_load   = 1'b0;
            mem_wb_bubble = 1'b1;
            // An outstanding fetch may still complete while the data side is frozen.
            if (state_q == DRAIN && imem_resp) begin
                state_d = RUN;
            end
        end else if (flush) begin
            pc_sel_target = 1'b1;
            if_de_bubble  = 1'b1;
            de_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = imem_resp ? RUN : DRAIN;
        end else if (state_q == DRAIN) begin
            // The fetch in flight belongs to the wrong path: discard it and hold the target PC.
            pc_load      = 1'b0;
            if_de_bubble = 1'b1;
            if (imem_resp) begin
                state_d = RUN;
            end
        end else if (load_use) begin
            pc_load      = 1'b0;
            if_de_load   = 1'b0;
            de_ex_bubble = 1'b1;
        end else if (!imem_resp) begin
            pc_load      = 1'b0;
            if_de_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_load && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign drain        = (state_q == DRAIN);
    assign stall_cycles = stall_cycles_q;

endmodule
